// File: rtl/fpu_norm_pack.sv
// ---------------------------------------------------------------------------
// fpu_norm_pack
//   Final stage of a single-precision adder. It takes the unnormalized sum from
//   the adder stage, normalizes it one bit per cycle (right shift with
//   round-to-nearest-even on carry-out, left shift on cancellation), then packs
//   it into an IEEE-754 single. Special cases flagged by the adder stage bypass
//   normalization and produce a fixed encoding directly.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   add_i        {sign[33], exp[32:25], man[24:0]}; man[24] carry, man[23] hidden
//   exception_i  special-case code, 0 = normal operand
//   valid_i      add_i / exception_i valid (accepted only while ready_o = 1)
//   ready_o      block is idle and can accept an operand
//   result_o     packed IEEE-754 single (registered)
//   valid_o      result_o valid; held until ready_i = 1
//   ready_i      downstream accepts result_o
//   overflow_o   result saturated to infinity (qualified by valid_o)
//   zero_o       result is +0 (qualified by valid_o)
// ---------------------------------------------------------------------------
module fpu_norm_pack (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [33:0] add_i,
  input  logic [2:0]  exception_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [31:0] result_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        overflow_o,
  output logic        zero_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } state_e;

  // Worst legitimate operand needs 24 NORM cycles (23 left shifts + exit);
  // the 25th cycle is forced to PACK so a corrupted mantissa cannot stall us.
  localparam logic [4:0] NORM_LAST_CNT = 5'd24;

  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  state_e      state_r, state_s;
  logic        sign_r,  sign_s;
  logic [9:0]  exp_r,   exp_s;
  logic [24:0] man_r,   man_s;
  logic [4:0]  cnt_r,   cnt_s;
  logic [31:0] result_r, result_s;
  logic        ovf_r,   ovf_s;
  logic        zero_r,  zero_s;

  // Fixed encoding for a special-case code from the adder stage.
  function automatic logic [31:0] exc_result(input logic [2:0] code);
    logic [31:0] r;
    case (code)
      3'b010:  r = POS_INF;
      3'b011:  r = NEG_INF;
      default: r = QNAN;
    endcase
    return r;
  endfunction

  // Shift right by one; round-to-nearest-even on the single dropped bit.
  // A carry back into bit 24 is left for the next NORM cycle to handle.
  function automatic logic [24:0] shift_round(input logic [24:0] man);
    logic [24:0] sh;
    sh = {1'b0, man[24:1]};
    if (man[0] && sh[0]) begin
      sh = sh + 25'd1;
    end else begin
      sh = sh;
    end
    return sh;
  endfunction

  // Pack a normalized value: returns {overflow, zero, result}.
  function automatic logic [33:0] pack_result(input logic        sign,
                                              input logic [9:0]  exp,
                                              input logic [24:0] man);
    logic [33:0] r;
    if (man == 25'd0) begin
      r = {1'b0, 1'b1, 32'h0000_0000};
    end else if (exp >= 10'd255) begin
      r = {1'b1, 1'b0, sign, 8'hFF, 23'd0};
    end else if (!man[23]) begin
      // Hidden bit still clear means exp bottomed out at 1: denormal.
      r = {1'b0, 1'b0, sign, 8'h00, man[22:0]};
    end else begin
      r = {1'b0, 1'b0, sign, exp[7:0], man[22:0]};
    end
    return r;
  endfunction

  // Next-state and datapath update; everything holds unless a branch changes it.
  always_comb begin
    state_s  = state_r;
    sign_s   = sign_r;
    exp_s    = exp_r;
    man_s    = man_r;
    cnt_s    = cnt_r;
    result_s = result_r;
    ovf_s    = ovf_r;
    zero_s   = zero_r;

    case (state_r)
      IDLE: begin
        if (valid_i) begin
          sign_s = add_i[33];
          // Exponent 0 carries the same scale as exponent 1 (denormal range).
          exp_s  = (add_i[32:25] == 8'd0) ? 10'd1 : {2'b00, add_i[32:25]};
          man_s  = add_i[24:0];
          cnt_s  = 5'd0;
          if (exception_i != 3'd0) begin
            state_s  = DONE;
            result_s = exc_result(exception_i);
            ovf_s    = 1'b0;
            zero_s   = 1'b0;
          end else begin
            state_s = NORM;
          end
        end else begin
          state_s = IDLE;
        end
      end

      NORM: begin
        cnt_s = cnt_r + 5'd1;
        if (man_r == 25'd0) begin
          state_s = PACK;
        end else if (cnt_r == NORM_LAST_CNT) begin
          state_s = PACK;
        end else if (man_r[24]) begin
          man_s   = shift_round(man_r);
          exp_s   = exp_r + 10'd1;
          state_s = NORM;
        end else if (!man_r[23] && (exp_r > 10'd1)) begin
          man_s   = {man_r[23:0], 1'b0};
          exp_s   = exp_r - 10'd1;
          state_s = NORM;
        end else begin
          state_s = PACK;
        end
      end

      PACK: begin
        {ovf_s, zero_s, result_s} = pack_result(sign_r, exp_r, man_r);
        state_s = DONE;
      end

      DONE: begin
        if (ready_i) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, operand and output registers; reset clears everything immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      sign_r   <= 1'b0;
      exp_r    <= 10'd0;
      man_r    <= 25'd0;
      cnt_r    <= 5'd0;
      result_r <= 32'h0000_0000;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      sign_r   <= sign_s;
      exp_r    <= exp_s;
      man_r    <= man_s;
      cnt_r    <= cnt_s;
      result_r <= result_s;
      ovf_r    <= ovf_s;
      zero_r   <= zero_s;
    end
  end

  assign ready_o    = (state_r == IDLE);
  assign valid_o    = (state_r == DONE);
  assign result_o   = result_r;
  assign overflow_o = ovf_r;
  assign zero_o     = zero_r;

endmodule
